// File: rtl/sensor_sched_pkg.sv
// sensor_sched_pkg: shared command codes, address base and FSM state encoding for sensor_poll_scheduler
package sensor_sched_pkg;
  localparam logic [7:0] CMD_STAT   = 8'h31;
  localparam logic [7:0] CMD_TEMP   = 8'h32;
  localparam logic [7:0] CMD_UMID   = 8'h33;
  localparam logic [7:0] CMD_TC_ON  = 8'h34;
  localparam logic [7:0] CMD_UC_ON  = 8'h35;
  localparam logic [7:0] CMD_TC_OFF = 8'h36;
  localparam logic [7:0] CMD_UC_OFF = 8'h37;
  localparam logic [7:0] ADDR_BASE  = 8'h31;
  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_ISSUE        = 4'd1,
    S_WAIT_SENSOR  = 4'd2,
    S_WAIT_DECODER = 4'd3
  } state_t;
endpackage

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: combinational round-robin pick over 16 slots, searching from the slot after last
// Ports: req (request mask), last (previously granted slot), gnt (one-hot grant, 0 if no request), idx (granted slot)
module rr_arbiter16 (
  input  logic [15:0] req,
  input  logic [3:0]  last,
  output logic [15:0] gnt,
  output logic [3:0]  idx
);
  // Scan from farthest to nearest so the nearest requesting slot after last wins.
  always_comb begin
    idx = last;
    for (int k = 16; k >= 1; k--) idx = req[last + 4'(k)] ? last + 4'(k) : idx;
    gnt = {15'b0, |req} << idx;
  end
endmodule

// File: rtl/sensor_poll_scheduler.sv
// sensor_poll_scheduler: serialises one-shot and round-robin continuous accesses to eight DHT sensor interfaces
// Inputs : clk, rst (sync, active high), data_received/data (command strobe), done_sensors, data_sensors,
//          response_sensors, done_decoder
// Outputs: en_sensors, command_sensor, address_sensor, data_sensor_o, response_sensor_o, en_decoder_o,
//          cmd_dropped, cmd_invalid, state_o
// Macro  : SENSOR_TIMEOUT_EN adds a WAIT_SENSOR cycle limit (TIMEOUT_CYC) answered with TIMEOUT_RESP
module sensor_poll_scheduler
  import sensor_sched_pkg::*;
#(
  parameter logic [31:0] POLL_GAP     = 32'd50_000_000
`ifdef SENSOR_TIMEOUT_EN
  ,
  parameter logic [31:0] TIMEOUT_CYC  = 32'd100_000_000,
  parameter logic [7:0]  TIMEOUT_RESP = 8'h1F
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_received,
  input  logic [15:0] data,
  input  logic [7:0]  done_sensors,
  input  logic [63:0] data_sensors,
  input  logic [47:0] response_sensors,
  input  logic        done_decoder,
  output logic [7:0]  en_sensors,
  output logic [7:0]  command_sensor,
  output logic [7:0]  address_sensor,
  output logic [7:0]  data_sensor_o,
  output logic [7:0]  response_sensor_o,
  output logic        en_decoder_o,
  output logic        cmd_dropped,
  output logic        cmd_invalid,
  output logic [3:0]  state_o
);
  state_t state, state_d;
  logic pend_v, cont, take_pend, cmd_ok, one_shot, mask_op, cont_go, store, sens_done, dec_done, tmo;
  logic [15:0] pend, req, gnt;
  logic [7:0] temp_mask, umid_mask, p_cmd, p_addr;
  logic [3:0] last, gnt_idx;
  logic [2:0] idx, p_idx;
  logic [31:0] gap;
  assign p_cmd     = pend[15:8];
  assign p_addr    = pend[7:0];
  assign p_idx     = p_addr[2:0] - 3'd1;
  assign take_pend = state == S_IDLE && pend_v;
  assign cmd_ok    = p_addr >= ADDR_BASE && p_addr <= ADDR_BASE + 8'd7 && p_cmd >= CMD_STAT && p_cmd <= CMD_UC_OFF;
  assign one_shot  = take_pend && cmd_ok && p_cmd <= CMD_UMID;
  assign mask_op   = take_pend && cmd_ok && p_cmd >= CMD_TC_ON;
  assign cont_go   = state == S_IDLE && !pend_v && |gnt && gap == '0;
  // A strobe may refill the pending slot in the same cycle it is consumed.
  assign store     = data_received && (!pend_v || take_pend);
  assign sens_done = state == S_WAIT_SENSOR && done_sensors[idx];
  // The cycle carrying en_decoder_o never counts as the decoder's completion.
  assign dec_done  = state == S_WAIT_DECODER && !en_decoder_o && done_decoder;
  assign en_sensors  = state == S_ISSUE ? 8'b1 << idx : 8'b0;
  assign cmd_dropped = data_received && !store;
  assign cmd_invalid = take_pend && !cmd_ok;
  assign state_o     = state;
  always_comb begin
    req = '0;
    for (int i = 0; i < 8; i++) req[2*i +: 2] = {umid_mask[i], temp_mask[i]};
  end
  rr_arbiter16 u_arb (.req(req), .last(last), .gnt(gnt), .idx(gnt_idx));
`ifdef SENSOR_TIMEOUT_EN
  logic [31:0] tcnt;
  assign tmo = state == S_WAIT_SENSOR && !done_sensors[idx] && tcnt == TIMEOUT_CYC - 32'd1;
  always_ff @(posedge clk) tcnt <= (rst || state != S_WAIT_SENSOR) ? '0 : tcnt + 32'd1;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state;
    state_d = (one_shot || cont_go) ? S_ISSUE :
              state == S_ISSUE      ? S_WAIT_SENSOR :
              (sens_done || tmo)    ? S_WAIT_DECODER :
              dec_done              ? S_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      pend_v            <= 1'b0;
      pend              <= '0;
      temp_mask         <= '0;
      umid_mask         <= '0;
      last              <= '0;
      gap               <= '0;
      idx               <= '0;
      cont              <= 1'b0;
      command_sensor    <= '0;
      address_sensor    <= '0;
      data_sensor_o     <= '0;
      response_sensor_o <= '0;
      en_decoder_o      <= 1'b0;
    end else begin
      state  <= state_d;
      pend_v <= store || (pend_v && !take_pend);
      if (store) pend <= data;
      if (mask_op) begin
        temp_mask[p_idx] <= p_cmd == CMD_TC_ON ? 1'b1 : p_cmd == CMD_TC_OFF ? 1'b0 : temp_mask[p_idx];
        umid_mask[p_idx] <= p_cmd == CMD_UC_ON ? 1'b1 : p_cmd == CMD_UC_OFF ? 1'b0 : umid_mask[p_idx];
      end
      if (one_shot) begin
        command_sensor <= p_cmd;
        address_sensor <= p_addr;
        idx            <= p_idx;
        cont           <= 1'b0;
      end else if (cont_go) begin
        command_sensor <= gnt_idx[0] ? CMD_UMID : CMD_TEMP;
        address_sensor <= ADDR_BASE + {5'b0, gnt_idx[3:1]};
        idx            <= gnt_idx[3:1];
        last           <= gnt_idx;
        cont           <= 1'b1;
      end
      if (sens_done) begin
        data_sensor_o     <= data_sensors[8*idx +: 8];
        response_sensor_o <= {2'b00, response_sensors[6*idx +: 6]};
      end
`ifdef SENSOR_TIMEOUT_EN
      else if (tmo) begin
        data_sensor_o     <= '0;
        response_sensor_o <= TIMEOUT_RESP;
      end
`endif
      en_decoder_o <= sens_done || tmo;
      gap <= (dec_done && cont) ? POLL_GAP : gap != '0 ? gap - 32'd1 : gap;
    end
  end
endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// tb_sensor_poll_scheduler: directed checks of one-shot, continuous, pending/drop, invalid, timeout and reset behaviour
module tb_sensor_poll_scheduler;
  logic clk = 1'b0, rst = 1'b1, data_received = 1'b0, done_decoder = 1'b0;
  logic [15:0] data = '0;
  logic [7:0] done_sensors = '0;
  logic [63:0] data_sensors = '0;
  logic [47:0] response_sensors = '0;
  logic [7:0] en_sensors, command_sensor, address_sensor, data_sensor_o, response_sensor_o;
  logic en_decoder_o, cmd_dropped, cmd_invalid;
  logic [3:0] state_o;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sensor_poll_scheduler #(
    .POLL_GAP(32'd4)
`ifdef SENSOR_TIMEOUT_EN
    , .TIMEOUT_CYC(32'd10), .TIMEOUT_RESP(8'h1F)
`endif
  ) dut (
    .clk(clk), .rst(rst), .data_received(data_received), .data(data),
    .done_sensors(done_sensors), .data_sensors(data_sensors), .response_sensors(response_sensors),
    .done_decoder(done_decoder), .en_sensors(en_sensors), .command_sensor(command_sensor),
    .address_sensor(address_sensor), .data_sensor_o(data_sensor_o), .response_sensor_o(response_sensor_o),
    .en_decoder_o(en_decoder_o), .cmd_dropped(cmd_dropped), .cmd_invalid(cmd_invalid), .state_o(state_o)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic all_zero(input string tag);
    check(tag, {en_sensors, command_sensor, address_sensor, data_sensor_o, response_sensor_o,
                en_decoder_o, cmd_dropped, cmd_invalid, state_o}, 64'd0);
  endtask
  task automatic send(input logic [7:0] c, input logic [7:0] a, input logic exp_drop, input logic exp_inv);
    data = {c, a};
    data_received = 1'b1;
    #1 check("dropped", cmd_dropped, exp_drop);
    @(negedge clk);
    data_received = 1'b0;
    #1 check("invalid", cmd_invalid, exp_inv);
  endtask
  task automatic wait_issue(input string tag, input logic [7:0] e, input logic [7:0] c, input logic [7:0] a,
                            input int lo, input int hi);
    int n = 0;
    while (en_sensors == 8'd0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_en"}, en_sensors, e);
    check({tag, "_cmd"}, command_sensor, c);
    check({tag, "_addr"}, address_sensor, a);
    check({tag, "_lat"}, n >= lo && n <= hi, 1);
    @(negedge clk);
    check({tag, "_pulse"}, en_sensors, 0);
    check({tag, "_ws"}, state_o, 2);
  endtask
  task automatic complete(input string tag, input int i, input logic [7:0] d, input logic [5:0] r);
    done_sensors = 8'(1 << i);
    data_sensors = 64'(d) << (8 * i);
    response_sensors = 48'(r) << (6 * i);
    @(negedge clk);
    done_sensors = '0;
    check({tag, "_wd"}, state_o, 3);
    check({tag, "_endec"}, en_decoder_o, 1);
    check({tag, "_data"}, data_sensor_o, d);
    check({tag, "_resp"}, response_sensor_o, {2'b00, r});
    @(negedge clk);
    check({tag, "_endec_off"}, en_decoder_o, 0);
    done_decoder = 1'b1;
    @(negedge clk);
    done_decoder = 1'b0;
    check({tag, "_idle"}, state_o, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    all_zero("reset");
    // one-shot temperature read of sensor 2
    send(8'h32, 8'h33, 0, 0);
    wait_issue("t1", 8'h04, 8'h32, 8'h33, 1, 1);
    complete("t1", 2, 8'h1A, 6'h05);
    check("t1_cmd_held", command_sensor, 8'h32);
    // continuous temp s0 and umid s7 alternate with a gap
    send(8'h34, 8'h31, 0, 0);
    wait_issue("c1", 8'h01, 8'h32, 8'h31, 1, 3);
    send(8'h35, 8'h38, 0, 0);
    complete("c1", 0, 8'h11, 6'h01);
    wait_issue("c2", 8'h80, 8'h33, 8'h38, 4, 6);
    complete("c2", 7, 8'h22, 6'h02);
    wait_issue("c3", 8'h01, 8'h32, 8'h31, 4, 6);
    complete("c3", 0, 8'h33, 6'h03);
    wait_issue("c4", 8'h80, 8'h33, 8'h38, 4, 6);
    complete("c4", 7, 8'h44, 6'h04);
    // one-shot during the gap is not delayed
    send(8'h31, 8'h35, 0, 0);
    wait_issue("os", 8'h10, 8'h31, 8'h35, 1, 1);
    complete("os", 4, 8'h55, 6'h3F);
    wait_issue("c5", 8'h01, 8'h32, 8'h31, 1, 6);
    complete("c5", 0, 8'h66, 6'h06);
    // stop monitoring, then hold one strobe and drop the next
    send(8'h36, 8'h31, 0, 0);
    send(8'h37, 8'h38, 0, 0);
    send(8'h32, 8'h31, 0, 0);
    wait_issue("p1", 8'h01, 8'h32, 8'h31, 1, 1);
    send(8'h33, 8'h32, 0, 0);
    send(8'h33, 8'h33, 1, 0);
    complete("p1", 0, 8'h77, 6'h07);
    wait_issue("p2", 8'h02, 8'h33, 8'h32, 1, 1);
    complete("p2", 1, 8'h88, 6'h08);
    send(8'h39, 8'h31, 0, 1);
    send(8'h32, 8'h40, 0, 1);
    @(negedge clk);
    check("inv_no_issue", en_sensors, 0);
    check("inv_idle", state_o, 0);
    // sensor never answers
    send(8'h32, 8'h36, 0, 0);
    wait_issue("to", 8'h20, 8'h32, 8'h36, 1, 1);
    repeat (10) @(negedge clk);
`ifdef SENSOR_TIMEOUT_EN
    check("to_state", state_o, 3);
    check("to_resp", response_sensor_o, 8'h1F);
    check("to_data", data_sensor_o, 0);
    check("to_endec", en_decoder_o, 1);
    @(negedge clk);
    done_decoder = 1'b1;
    @(negedge clk);
    done_decoder = 1'b0;
    check("to_idle", state_o, 0);
`else
    check("to_stuck", state_o, 2);
    complete("to", 5, 8'h99, 6'h09);
`endif
    // reset while waiting on the decoder
    send(8'h34, 8'h33, 0, 0);
    wait_issue("r", 8'h04, 8'h32, 8'h33, 1, 3);
    done_sensors = 8'h04;
    data_sensors = 64'hAB << 16;
    @(negedge clk);
    done_sensors = '0;
    check("r_wd", state_o, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 all_zero("r_zero");
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | (en_sensors != 8'd0) | en_decoder_o;
    end
    check("r_no_poll", seen, 0);
    check("r_idle", state_o, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
